// File: rtl/cb_header_sequencer.sv
// -----------------------------------------------------------------------------
// cb_header_sequencer
//
// Splits each transport-block (TB) descriptor into a run of code-block (CB)
// headers for the encoder datapath. One descriptor is accepted at a time; one
// 64-bit header is emitted per code block. The sequence number runs globally
// across TBs and wraps 511 -> 0.
//
// Parameters:
//   CB_MAX_BYTES    maximum CB payload in bytes (1..2047)
//   CODE_RATE_SHIFT output length = input bits << shift, saturated to 16 bits
//                   (0..7 keeps the shifted value inside 21 bits)
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   tb_valid / tb_ready        descriptor handshake
//   tb_index, tb_tti           copied into every CB header of the TB
//   tb_length_bytes            TB payload length in bytes
//   cb_valid / cb_ready        header handshake
//   cb_hdr                     packed header, MSB to LSB:
//                              out_bits[15:0] in_bits[15:0] rsvd2[6:0]
//                              seq[8:0] tb_index[7:0] rsvd1[1:0] tti[1:0]
//                              last_cb rsvd0 header_type[1:0]
//   err_zero_len               one-cycle pulse after a zero-length TB is taken
//
// Optional feature (macro CB_SEQ_STATS_EN):
//   stat_tb_count[15:0]        accepted descriptors, including zero-length
//   stat_cb_count[31:0]        CB handshakes
// -----------------------------------------------------------------------------
module cb_header_sequencer #(
  parameter int CB_MAX_BYTES    = 1024,
  parameter int CODE_RATE_SHIFT = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        tb_valid,
  output logic        tb_ready,
  input  logic [7:0]  tb_index,
  input  logic [1:0]  tb_tti,
  input  logic [19:0] tb_length_bytes,
  output logic        cb_valid,
  input  logic        cb_ready,
  output logic [63:0] cb_hdr,
  output logic        err_zero_len
`ifdef CB_SEQ_STATS_EN
  ,
  output logic [15:0] stat_tb_count,
  output logic [31:0] stat_cb_count
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEG  = 1'b1
  } state_t;

  localparam logic [20:0] CB_MAX_W = 21'(CB_MAX_BYTES);

  // Builds the header for the CB that starts with 'rem' bytes still to send.
  function automatic logic [63:0] build_hdr(
    input logic [20:0] rem,
    input logic [8:0]  seq,
    input logic [7:0]  idx,
    input logic [1:0]  tti
  );
    logic [20:0] chunk;
    logic [20:0] in_bits;
    logic [20:0] out_bits;
    logic [15:0] out_sat;
    logic        last;
    chunk    = (rem < CB_MAX_W) ? rem : CB_MAX_W;
    in_bits  = chunk << 3;
    out_bits = in_bits << CODE_RATE_SHIFT;
    if (out_bits > 21'h00FFFF) begin
      out_sat = 16'hFFFF;
    end else begin
      out_sat = out_bits[15:0];
    end
    last = (rem <= CB_MAX_W);
    build_hdr = {out_sat, in_bits[15:0], 7'd0, seq, idx, 2'd0, tti,
                 last, 1'b0, 2'b01};
  endfunction

  state_t      state_r, state_nxt_s;
  logic [19:0] rem_r, rem_nxt_s;
  logic [7:0]  idx_r, idx_nxt_s;
  logic [1:0]  tti_r, tti_nxt_s;
  logic [8:0]  seq_r, seq_nxt_s;
  logic [63:0] cb_hdr_r, hdr_nxt_s;
  logic        cb_valid_r, valid_nxt_s;
  logic        tb_ready_r, tb_ready_nxt_s;
  logic        err_r, err_nxt_s;

  logic        tb_fire_s;
  logic        cb_fire_s;
  logic [20:0] rem_ext_s;
  logic [20:0] chunk_s;
  logic [20:0] rem_after_s;
  logic        last_s;
  logic [8:0]  seq_inc_s;

  assign tb_fire_s   = tb_valid && tb_ready_r;
  assign cb_fire_s   = cb_valid_r && cb_ready;
  assign rem_ext_s   = {1'b0, rem_r};
  assign chunk_s     = (rem_ext_s < CB_MAX_W) ? rem_ext_s : CB_MAX_W;
  // chunk never exceeds rem, so this cannot underflow
  assign rem_after_s = rem_ext_s - chunk_s;
  assign last_s      = (rem_ext_s <= CB_MAX_W);
  assign seq_inc_s   = seq_r + 9'd1;

  // Next-state and next-output logic; the header for the following CB is
  // prepared here so it can be registered on the handshake edge.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    idx_nxt_s   = idx_r;
    tti_nxt_s   = tti_r;
    seq_nxt_s   = seq_r;
    hdr_nxt_s   = cb_hdr_r;
    valid_nxt_s = cb_valid_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        valid_nxt_s = 1'b0;
        if (tb_fire_s) begin
          idx_nxt_s = tb_index;
          tti_nxt_s = tb_tti;
          rem_nxt_s = tb_length_bytes;
          if (tb_length_bytes == 20'd0) begin
            err_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_SEG;
            valid_nxt_s = 1'b1;
            hdr_nxt_s   = build_hdr({1'b0, tb_length_bytes}, seq_r, tb_index, tb_tti);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEG: begin
        if (cb_fire_s) begin
          seq_nxt_s = seq_inc_s;
          rem_nxt_s = rem_after_s[19:0];
          if (last_s) begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            hdr_nxt_s   = 64'd0;
          end else begin
            hdr_nxt_s = build_hdr(rem_after_s, seq_inc_s, idx_r, tti_r);
          end
        end else begin
          // stalled: header and valid held until the handshake
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
        hdr_nxt_s   = 64'd0;
      end
    endcase
    tb_ready_nxt_s = (state_nxt_s == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= ST_IDLE;
      rem_r      <= 20'd0;
      idx_r      <= 8'd0;
      tti_r      <= 2'd0;
      seq_r      <= 9'd0;
      cb_hdr_r   <= 64'd0;
      cb_valid_r <= 1'b0;
      tb_ready_r <= 1'b1;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rem_r      <= rem_nxt_s;
      idx_r      <= idx_nxt_s;
      tti_r      <= tti_nxt_s;
      seq_r      <= seq_nxt_s;
      cb_hdr_r   <= hdr_nxt_s;
      cb_valid_r <= valid_nxt_s;
      tb_ready_r <= tb_ready_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign tb_ready     = tb_ready_r;
  assign cb_valid     = cb_valid_r;
  assign cb_hdr       = cb_hdr_r;
  assign err_zero_len = err_r;

`ifdef CB_SEQ_STATS_EN
  logic [15:0] stat_tb_r;
  logic [31:0] stat_cb_r;

  // Free-running wrap-around event counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_tb_r <= 16'd0;
      stat_cb_r <= 32'd0;
    end else begin
      if (tb_fire_s) begin
        stat_tb_r <= stat_tb_r + 16'd1;
      end else begin
        stat_tb_r <= stat_tb_r;
      end
      if (cb_fire_s) begin
        stat_cb_r <= stat_cb_r + 32'd1;
      end else begin
        stat_cb_r <= stat_cb_r;
      end
    end
  end

  assign stat_tb_count = stat_tb_r;
  assign stat_cb_count = stat_cb_r;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cb_header_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cb_header_sequencer (default parameters: 1024-byte CBs,
// rate shift 1). Table of TB descriptors with hand-computed header lengths,
// plus hand-written sequences for bubbles, stalls, reset and seq wrap.
// -----------------------------------------------------------------------------
module tb_cb_header_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        tb_valid;
  logic        tb_ready;
  logic [7:0]  tb_index;
  logic [1:0]  tb_tti;
  logic [19:0] tb_length_bytes;
  logic        cb_valid;
  logic        cb_ready;
  logic [63:0] cb_hdr;
  logic        err_zero_len;
`ifdef CB_SEQ_STATS_EN
  logic [15:0] stat_tb_count;
  logic [31:0] stat_cb_count;
`endif

  cb_header_sequencer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .tb_valid        (tb_valid),
    .tb_ready        (tb_ready),
    .tb_index        (tb_index),
    .tb_tti          (tb_tti),
    .tb_length_bytes (tb_length_bytes),
    .cb_valid        (cb_valid),
    .cb_ready        (cb_ready),
    .cb_hdr          (cb_hdr),
    .err_zero_len    (err_zero_len)
`ifdef CB_SEQ_STATS_EN
    ,
    .stat_tb_count   (stat_tb_count),
    .stat_cb_count   (stat_cb_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [19:0] len;
    logic [7:0]  idx;
    logic [1:0]  tti;
    int          ncb;
    logic [15:0] in_last;
    logic [15:0] out_last;
  } tb_vec_t;

  localparam logic [15:0] FULL_IN  = 16'd8192;
  localparam logic [15:0] FULL_OUT = 16'd16384;

  int          tests;
  int          fails;
  logic [8:0]  exp_seq;
  int          exp_tb_cnt;
  int          exp_cb_cnt;
  logic [63:0] last_hdr;

  function automatic logic [63:0] pack_hdr(input logic [15:0] out_bits,
                                            input logic [15:0] in_bits,
                                            input logic [8:0]  seq,
                                            input logic [7:0]  idx,
                                            input logic [1:0]  tti,
                                            input logic        last);
    pack_hdr = {out_bits, in_bits, 7'd0, seq, idx, 2'd0, tti, last, 1'b0, 2'b01};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Present a descriptor, wait for tb_ready, and return just after the accept edge.
  task automatic send_tb(input logic [19:0] len, input logic [7:0] idx, input logic [1:0] tti);
    int n;
    tb_valid        = 1'b1;
    tb_index        = idx;
    tb_tti          = tti;
    tb_length_bytes = len;
    n = 0;
    while (!tb_ready && n < 50) begin
      step();
      n++;
    end
    if (!tb_ready) timeout_fail("send_tb_ready");
    step();
    tb_valid = 1'b0;
    exp_tb_cnt++;
    if (len != 20'd0) check("first_hdr_latency", {63'd0, cb_valid}, 64'd1);
  endtask

  // Wait for a header (cb_ready assumed 1), compare it, and take it.
  task automatic expect_hdr(input logic [15:0] in_bits, input logic [15:0] out_bits,
                            input logic last, input logic [7:0] idx, input logic [1:0] tti,
                            input string name);
    int n;
    n = 0;
    while (!cb_valid && n < 20) begin
      step();
      n++;
    end
    if (!cb_valid) begin
      timeout_fail(name);
    end else begin
      check(name, cb_hdr, pack_hdr(out_bits, in_bits, exp_seq, idx, tti, last));
      check("tb_ready_low_in_seg", {63'd0, tb_ready}, 64'd0);
      last_hdr = cb_hdr;
      step();
      exp_seq = exp_seq + 9'd1;
      exp_cb_cnt++;
    end
  endtask

  initial begin
    tb_vec_t     vecs[7];
    logic        pat[6];
    logic [63:0] got[$];
    logic [63:0] held;
    logic        was_stall;

    tests = 0;
    fails = 0;
    exp_seq = 9'd0;
    exp_tb_cnt = 0;
    exp_cb_cnt = 0;
    last_hdr = 64'd0;

    vecs[0] = '{len: 20'd2500, idx: 8'd7,   tti: 2'd2, ncb: 3, in_last: 16'd3616, out_last: 16'd7232};
    vecs[1] = '{len: 20'd2048, idx: 8'd3,   tti: 2'd1, ncb: 2, in_last: 16'd8192, out_last: 16'd16384};
    vecs[2] = '{len: 20'd1,    idx: 8'hAA,  tti: 2'd3, ncb: 1, in_last: 16'd8,    out_last: 16'd16};
    vecs[3] = '{len: 20'd1024, idx: 8'h55,  tti: 2'd0, ncb: 1, in_last: 16'd8192, out_last: 16'd16384};
    vecs[4] = '{len: 20'd1025, idx: 8'd1,   tti: 2'd1, ncb: 2, in_last: 16'd8,    out_last: 16'd16};
    vecs[5] = '{len: 20'd4000, idx: 8'hC3,  tti: 2'd2, ncb: 4, in_last: 16'd7424, out_last: 16'd14848};
    vecs[6] = '{len: 20'd2047, idx: 8'hFF,  tti: 2'd3, ncb: 2, in_last: 16'd8184, out_last: 16'd16368};

    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    tb_valid        = 1'b0;
    tb_index        = 8'd0;
    tb_tti          = 2'd0;
    tb_length_bytes = 20'd0;
    cb_ready        = 1'b1;
    aresetn         = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    step();

    // Reset values
    check("rst_tb_ready", {63'd0, tb_ready}, 64'd1);
    check("rst_cb_valid", {63'd0, cb_valid}, 64'd0);
    check("rst_cb_hdr", cb_hdr, 64'd0);
    check("rst_err", {63'd0, err_zero_len}, 64'd0);

    // Zero-length TB: one error pulse, no header
    send_tb(20'd0, 8'd9, 2'd1);
    check("zero_err_pulse", {63'd0, err_zero_len}, 64'd1);
    check("zero_no_valid", {63'd0, cb_valid}, 64'd0);
`ifdef CB_SEQ_STATS_EN
    check("zero_stat_tb", {48'd0, stat_tb_count}, 64'(exp_tb_cnt));
    check("zero_stat_cb", {32'd0, stat_cb_count}, 64'(exp_cb_cnt));
`endif
    step();
    check("zero_err_once", {63'd0, err_zero_len}, 64'd0);
    check("zero_no_valid_2", {63'd0, cb_valid}, 64'd0);
    check("zero_tb_ready", {63'd0, tb_ready}, 64'd1);

    // Table of descriptors, cb_ready held high
    for (int i = 0; i < 7; i++) begin
      send_tb(vecs[i].len, vecs[i].idx, vecs[i].tti);
      for (int k = 0; k < vecs[i].ncb; k++) begin
        if (k == vecs[i].ncb - 1)
          expect_hdr(vecs[i].in_last, vecs[i].out_last, 1'b1, vecs[i].idx, vecs[i].tti, "table_last_hdr");
        else
          expect_hdr(FULL_IN, FULL_OUT, 1'b0, vecs[i].idx, vecs[i].tti, "table_full_hdr");
      end
    end
    check("table_idle_after", {63'd0, cb_valid}, 64'd0);

    // TB boundary bubble: 2048 bytes then next TB presented immediately
    send_tb(20'd2048, 8'h10, 2'd0);
    expect_hdr(FULL_IN, FULL_OUT, 1'b0, 8'h10, 2'd0, "b2b_hdr0");
    expect_hdr(FULL_IN, FULL_OUT, 1'b1, 8'h10, 2'd0, "b2b_hdr1");
    check("bubble_tb_ready", {63'd0, tb_ready}, 64'd1);
    check("bubble_cb_valid", {63'd0, cb_valid}, 64'd0);
    tb_valid        = 1'b1;
    tb_index        = 8'h11;
    tb_tti          = 2'd3;
    tb_length_bytes = 20'd100;
    step();
    tb_valid = 1'b0;
    exp_tb_cnt++;
    check("next_tb_valid", {63'd0, cb_valid}, 64'd1);
    check("next_tb_hdr", cb_hdr, pack_hdr(16'd1600, 16'd800, exp_seq, 8'h11, 2'd3, 1'b1));
    step();
    exp_seq = exp_seq + 9'd1;
    exp_cb_cnt++;

    // Stall pattern on a 3000-byte TB
    cb_ready = 1'b0;
    send_tb(20'd3000, 8'h42, 2'd1);
    for (int i = 0; i < 6; i++) begin
      cb_ready  = pat[i];
      held      = cb_hdr;
      was_stall = cb_valid && !cb_ready;
      if (cb_valid && cb_ready) got.push_back(cb_hdr);
      check("stall_tb_ready", {63'd0, tb_ready}, 64'd0);
      step();
      if (was_stall) begin
        check("stall_valid_held", {63'd0, cb_valid}, 64'd1);
        check("stall_hdr_held", cb_hdr, held);
      end
    end
    cb_ready = 1'b1;
    check("stall_hdr_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check("stall_hdr0", got[0], pack_hdr(FULL_OUT, FULL_IN, exp_seq, 8'h42, 2'd1, 1'b0));
      check("stall_hdr1", got[1], pack_hdr(FULL_OUT, FULL_IN, exp_seq + 9'd1, 8'h42, 2'd1, 1'b0));
      check("stall_hdr2", got[2], pack_hdr(16'd15232, 16'd7616, exp_seq + 9'd2, 8'h42, 2'd1, 1'b1));
    end
    exp_seq = exp_seq + 9'd3;
    exp_cb_cnt += 3;
    check("stall_idle_after", {63'd0, cb_valid}, 64'd0);
`ifdef CB_SEQ_STATS_EN
    check("mid_stat_tb", {48'd0, stat_tb_count}, 64'(exp_tb_cnt));
    check("mid_stat_cb", {32'd0, stat_cb_count}, 64'(exp_cb_cnt));
`endif

    // Asynchronous reset during the second CB of a 4-CB TB
    send_tb(20'd4096, 8'h77, 2'd3);
    expect_hdr(FULL_IN, FULL_OUT, 1'b0, 8'h77, 2'd3, "rst_tb_hdr0");
    check("rst_tb_second_valid", {63'd0, cb_valid}, 64'd1);
    aresetn = 1'b0;
    #1;
    check("async_rst_cb_valid", {63'd0, cb_valid}, 64'd0);
    check("async_rst_tb_ready", {63'd0, tb_ready}, 64'd1);
    check("async_rst_cb_hdr", cb_hdr, 64'd0);
    step();
    aresetn = 1'b1;
    exp_seq = 9'd0;
    exp_tb_cnt = 0;
    exp_cb_cnt = 0;
    step();
    check("post_rst_idle", {63'd0, cb_valid}, 64'd0);
    send_tb(20'd100, 8'h05, 2'd1);
    expect_hdr(16'd800, 16'd1600, 1'b1, 8'h05, 2'd1, "post_rst_hdr");
    check("post_rst_single_cb", {63'd0, cb_valid}, 64'd0);

    // Sequence wrap: 171 TBs x 3 CBs from a fresh reset
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    exp_seq = 9'd0;
    exp_tb_cnt = 0;
    exp_cb_cnt = 0;
    step();
    for (int t = 0; t < 171; t++) begin
      send_tb(20'd3072, 8'(t), 2'(t));
      expect_hdr(FULL_IN, FULL_OUT, 1'b0, 8'(t), 2'(t), "wrap_hdr0");
      expect_hdr(FULL_IN, FULL_OUT, 1'b0, 8'(t), 2'(t), "wrap_hdr1");
      expect_hdr(FULL_IN, FULL_OUT, 1'b1, 8'(t), 2'(t), "wrap_hdr2");
    end
    check("wrap_final_seq", {55'd0, last_hdr[24:16]}, 64'd0);
    check("wrap_cb_total", 64'(exp_cb_cnt), 64'd513);
`ifdef CB_SEQ_STATS_EN
    check("wrap_stat_tb", {48'd0, stat_tb_count}, 64'd171);
    check("wrap_stat_cb", {32'd0, stat_cb_count}, 64'd513);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cb_header_sequencer.md
# cb_header_sequencer

Control-path sequencer that splits each transport-block (TB) descriptor into a run of code-block (CB) headers for the encoder datapath. It accepts one TB descriptor at a time over a valid/ready handshake and emits one 64-bit CB header per code block over a second valid/ready handshake. Each header carries the segment length, a global sequence number and a last-CB flag. The block sits between the TB header parser and the CB encoder input stage.

## Interface
- CB_MAX_BYTES, 1024: maximum CB payload in bytes; legal range 1..2047.
- CODE_RATE_SHIFT, 1: output length is the input length in bits shifted left by this amount, saturated to 16 bits.
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- tb_valid  in  1  TB descriptor valid.
- tb_ready  out  1  sequencer can accept a descriptor.
- tb_index  in  8  TB index; copied to every CB.
- tb_tti  in  2  TTI; copied to every CB.
- tb_length_bytes  in  20  TB payload length in bytes.
- cb_valid  out  1  CB header valid.
- cb_ready  in  1  downstream accepts the header.
- cb_hdr  out  64  packed header, MSB to LSB:
  - output_code_length_bits[15:0]
  - input_code_length_bits[15:0]
  - reserved2[6:0]
  - sequence_number[8:0]
  - tb_index[7:0]
  - reserved1[1:0]
  - tti[1:0]
  - last_cb
  - reserved0
  - header_type[1:0]
- err_zero_len  out  1  one-cycle pulse when a zero-length TB is accepted.

## Operation
- FSM states: IDLE, SEG.
- **IDLE**
  - tb_ready=1, cb_valid=0.
  - On tb_valid&&tb_ready, latch tb_index, tti and rem=tb_length_bytes.
  - rem==0: stay in IDLE, pulse err_zero_len next cycle, emit no CB.
  - rem!=0: go to SEG.
- **SEG**
  - tb_ready=0, cb_valid=1.
  - chunk = min(rem, CB_MAX_BYTES).
  - input_code_length_bits = chunk*8.
  - output_code_length_bits = min(chunk*8 << CODE_RATE_SHIFT, 16'hFFFF).
  - last_cb = (rem <= CB_MAX_BYTES).
  - header_type = 2'b01; all reserved fields = 0.
  - On cb_valid&&cb_ready: rem -= chunk and seq increments. If last_cb, go to IDLE; otherwise stay in SEG with the next header registered.
- The sequence number is a 9-bit global counter across TBs; it wraps 511→0 and changes only on a CB handshake.
- An exact multiple of CB_MAX_BYTES produces no trailing empty CB.
- Per-TB CB count is ceil(len/CB_MAX_BYTES).
- All header arithmetic uses 21-bit unsigned intermediates; rem never underflows.

## Timing
- Reset values: tb_ready=1, cb_valid=0, cb_hdr=0, err_zero_len=0, seq=0, state=IDLE.
- Latency: descriptor accepted at edge N gives cb_valid=1 with the first header at N+1.
- Back-to-back CBs of one TB: one header per cycle while cb_ready=1.
- Between TBs: tb_ready returns 1 the cycle after the last-CB handshake, so each TB boundary costs one bubble cycle.
- Handshake hold: while cb_valid&&!cb_ready, cb_hdr is held stable. cb_valid never drops without a handshake (reset excepted).
- cb_valid does not depend combinationally on cb_ready. tb_ready is a registered function of state.
- Asynchronous reset mid-TB:
  - outputs immediately take their reset values;
  - remaining CBs are discarded;
  - seq returns to 0.

## Configuration
- Macro: CB_SEQ_STATS_EN.
- Defined: the block adds outputs stat_tb_count[15:0] and stat_cb_count[31:0].
  - stat_tb_count increments per accepted descriptor, including zero-length ones.
  - stat_cb_count increments per CB handshake.
  - Both wrap, reset to 0, and update one cycle after the event.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Default parameters, TB len 2500, index 7, tti 2, cb_ready=1:
  - three headers: input bits 8192/8192/3616, output bits 16384/16384/7232;
  - seq 0,1,2; last_cb=1 on the third only;
  - header_type=1, tb_index=7, tti=2 on all three.
- TB len 2048:
  - exactly two CBs, both input bits 8192; last_cb on the second.
  - The next TB's first header has seq 2 and appears 2 cycles after the last handshake.
- TB len 3000 with cb_ready toggled 1-0-0-1-0-1:
  - cb_hdr stable during stalls; no header lost or duplicated;
  - tb_ready=0 throughout SEG.
- TB len 0:
  - err_zero_len pulses once, no cb_valid, seq unchanged;
  - with CB_SEQ_STATS_EN, stat_tb_count=1 and stat_cb_count=0.
- 171 TBs of 3072 bytes (513 CBs):
  - seq runs 0..511, then 0; the final header carries seq 0.
- Deassert aresetn for 1 cycle during the second CB of a 4-CB TB:
  - cb_valid=0 and tb_ready=1 immediately;
  - after release, a new TB len 100 yields one CB with seq 0, input bits 800, last_cb=1.
